// File: rtl/version_pkg.sv
// version_pkg: build identity constants, response lengths, responder state type and nibble-to-ASCII helper
package version_pkg;
  localparam logic [7:0]  C_VERSION_MAJOR  = 8'h00;
  localparam logic [7:0]  C_VERSION_MINOR  = 8'h00;
  localparam logic [7:0]  C_VERSION_PATCH  = 8'h00;
  localparam logic [7:0]  C_VERSION_BUILD  = 8'h3B;
  localparam logic [15:0] C_VERSION_YEAR   = 16'h2025;
  localparam logic [7:0]  C_VERSION_MONTH  = 8'h11;
  localparam logic [7:0]  C_VERSION_DAY    = 8'h07;
  localparam logic [7:0]  C_VERSION_HOUR   = 8'h16;
  localparam logic [7:0]  C_VERSION_MINUTE = 8'h19;
  localparam logic [7:0]  C_VERSION_SECOND = 8'h55;
  localparam int C_VERSION_RESP_LEN_CRLF = 33;
  localparam int C_VERSION_RESP_BIN_LEN  = 12;
  typedef enum logic {IDLE, SEND} version_resp_state_t;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/version_char_rom.sv
// version_char_rom: combinational map from response index (+ binary mode) to response byte
//   idx  : byte position within the response line
//   mode : 0 = ASCII line, 1 = raw binary record
//   data : byte at that position
module version_char_rom #(
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic [5:0] idx,
  input  logic       mode,
  output logic [7:0] data
);
  import version_pkg::*;
  function automatic logic [15:0] hex2(input logic [7:0] b);
    return {hex_ascii(b[7:4]), hex_ascii(b[3:0])};
  endfunction
  logic [247:0] line;
  logic [95:0]  bin;
  logic [4:0]   ai;
  logic [3:0]   bi;
  logic [7:0]   asc;
  assign line = {hex2(C_VERSION_MAJOR), ".", hex2(C_VERSION_MINOR), ".", hex2(C_VERSION_PATCH), ".",
                 hex2(C_VERSION_BUILD), " ", hex2(C_VERSION_YEAR[15:8]), hex2(C_VERSION_YEAR[7:0]), "-",
                 hex2(C_VERSION_MONTH), "-", hex2(C_VERSION_DAY), " ", hex2(C_VERSION_HOUR), ":",
                 hex2(C_VERSION_MINUTE), ":", hex2(C_VERSION_SECOND)};
  assign bin = {C_VERSION_MAJOR, C_VERSION_MINOR, C_VERSION_PATCH, C_VERSION_BUILD, C_VERSION_YEAR,
                C_VERSION_MONTH, C_VERSION_DAY, C_VERSION_HOUR, C_VERSION_MINUTE, C_VERSION_SECOND, 8'h0A};
  assign ai = 5'd30 - idx[4:0];
  assign bi = 4'd11 - idx[3:0];
  assign asc = idx < 6'd31 ? line[{ai, 3'b000} +: 8] : (idx == 6'd31 && EOL_CRLF) ? 8'h0D : 8'h0A;
  assign data = !mode ? asc : idx < 6'd12 ? bin[{bi, 3'b000} +: 8] : 8'h0A;
endmodule

// File: rtl/version_responder.sv
// version_responder: answers a version-query command byte with the build version/timestamp line
//   cmd_data/cmd_valid/cmd_ready : command byte stream from UART RX
//   tx_data/tx_valid/tx_ready    : response byte stream to UART TX
//   busy                         : response in progress
//   resp_count                   : completed responses (wraps)
//   VERSION_RESP_BIN_EN          : when defined, 'v' returns a 12-byte raw binary record
module version_responder #(
  parameter logic [7:0] CMD_CHAR = 8'h56,
  parameter bit         EOL_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [15:0] resp_count
);
  import version_pkg::*;
  version_resp_state_t state, state_n;
  logic [5:0] idx, idx_n, last;
  logic       mode, mode_n, bin_hit, fire, done;
  logic [7:0] rom_byte;
`ifdef VERSION_RESP_BIN_EN
  assign bin_hit = cmd_data == 8'h76;
`else
  assign bin_hit = 1'b0;
`endif
  assign cmd_ready = !rst && state == IDLE;
  assign busy = state == SEND;
  assign last = mode ? 6'(C_VERSION_RESP_BIN_LEN - 1) :
                EOL_CRLF ? 6'(C_VERSION_RESP_LEN_CRLF - 1) : 6'(C_VERSION_RESP_LEN_CRLF - 2);
  assign fire = tx_valid && tx_ready;
  assign done = state == SEND && fire && idx == last;
  // The ROM is addressed with the next index so tx_data is registered alongside the index.
  always_comb begin
    state_n = state;
    idx_n = idx;
    mode_n = mode;
    if (cmd_ready && cmd_valid && (cmd_data == CMD_CHAR || bin_hit)) begin
      state_n = SEND;
      idx_n = 6'd0;
      mode_n = bin_hit;
    end else if (done) state_n = IDLE;
    else if (state == SEND && fire) idx_n = idx + 6'd1;
  end
  version_char_rom #(.EOL_CRLF(EOL_CRLF)) u_rom (
    .idx (idx_n),
    .mode(mode_n),
    .data(rom_byte)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= 6'd0;
      mode <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
      resp_count <= 16'd0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      mode <= mode_n;
      tx_valid <= state_n == SEND;
      tx_data <= state_n == SEND ? rom_byte : 8'h00;
      if (done) resp_count <= resp_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_version_responder.sv
// tb_version_responder: randomized self-checking bench for version_responder (CRLF and LF builds)
module tb_version_responder;
  logic clk = 1'b0, rst;
  logic [7:0] cmd_data, tx_data, l_cmd_data, l_tx_data;
  logic cmd_valid, cmd_ready, tx_valid, tx_ready, busy;
  logic l_cmd_valid, l_cmd_ready, l_tx_valid, l_tx_ready, l_busy;
  logic [15:0] resp_count, l_resp_count;
  int total = 0, bad = 0;
  logic [7:0] got[$];
  int hold_err, side_err, cyc;
  string line_s = "00.00.00.3B 2025-11-07 16:19:55";
  string crlf_s, lf_s;

  always #5 clk = ~clk;

  version_responder u_dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .resp_count(resp_count)
  );
  version_responder #(.EOL_CRLF(1'b0)) u_lf (
    .clk(clk), .rst(rst), .cmd_data(l_cmd_data), .cmd_valid(l_cmd_valid), .cmd_ready(l_cmd_ready),
    .tx_data(l_tx_data), .tx_valid(l_tx_valid), .tx_ready(l_tx_ready), .busy(l_busy), .resp_count(l_resp_count)
  );

  task automatic send_cmd(input bit w, input logic [7:0] c, output bit ok);
    ok = 0;
    if (w) begin l_cmd_data = c; l_cmd_valid = 1; end else begin cmd_data = c; cmd_valid = 1; end
    for (int i = 0; i < 200 && !ok; i++) begin
      if ((w ? l_cmd_ready : cmd_ready) === 1'b1) begin
        @(posedge clk);
        ok = 1;
      end
      @(negedge clk);
    end
    if (w) l_cmd_valid = 0; else cmd_valid = 0;
  endtask

  task automatic collect(input bit w, input int n, input int pct, output bit ok);
    bit ph = 0, v, r;
    logic [7:0] pd = 8'h00, d;
    got = {};
    hold_err = 0;
    side_err = 0;
    cyc = 0;
    for (int i = 0; i < 3000 && got.size() < n; i++) begin
      v = (w ? l_tx_valid : tx_valid) === 1'b1;
      d = w ? l_tx_data : tx_data;
      if (ph && (!v || d !== pd)) hold_err++;
      if (v && ((w ? l_busy : busy) !== 1'b1 || (w ? l_cmd_ready : cmd_ready) !== 1'b0)) side_err++;
      r = $urandom_range(99) < pct;
      if (w) l_tx_ready = r; else tx_ready = r;
      if (v && r) got.push_back(d);
      ph = v && !r;
      pd = d;
      cyc++;
      @(negedge clk);
    end
    ok = got.size() == n;
    if (w) l_tx_ready = 0; else tx_ready = 0;
  endtask

  function automatic int first_diff(input string e, input int off);
    for (int i = 0; i < e.len(); i++)
      if (off + i >= got.size() || got[off + i] !== e[i]) return i;
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0 || l_cmd_ready !== 1'b0) begin
      bad++; $display("FAIL reset_cmd_ready got=%b/%b exp=0", cmd_ready, l_cmd_ready);
    end
    rst = 0;
    @(negedge clk);
    total++;
    if ({tx_valid, busy, tx_data} !== 10'h0) begin
      bad++; $display("FAIL reset_outputs got valid=%b busy=%b data=%h exp 0/0/00", tx_valid, busy, tx_data);
    end
    total++;
    if (resp_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", resp_count); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_drop;
    logic [7:0] b;
    bit ok;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) b = 8'h41; else if (i == 1) b = 8'h00; else if (i == 2) b = 8'hFF;
      else do b = 8'($urandom_range(255)); while (b == 8'h56 || b == 8'h76);
      send_cmd(0, b, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL drop_accept byte=%h got=not_accepted exp=accepted", b); end
      repeat (2) begin
        total++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
          bad++; $display("FAIL drop_quiet byte=%h got valid=%b busy=%b exp 0/0", b, tx_valid, busy);
        end
        @(negedge clk);
      end
    end
    total++;
    if (resp_count !== 16'd0) begin bad++; $display("FAIL drop_count got=%0d exp=0", resp_count); end
  endtask

  task automatic test_ascii;
    bit ok;
    int k;
    send_cmd(0, 8'h56, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ascii_accept got=not_accepted exp=accepted"); end
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h30 || busy !== 1'b1) begin
      bad++; $display("FAIL ascii_latency got valid=%b data=%h busy=%b exp 1/30/1", tx_valid, tx_data, busy);
    end
    collect(0, 33, 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ascii_len got=%0d exp=33", got.size()); end
    k = first_diff(crlf_s, 0);
    total++;
    if (k >= 0) begin bad++; $display("FAIL ascii_line pos=%0d got=%h exp=%h", k, got[k], crlf_s[k]); end
    total++;
    if (cyc != 33) begin bad++; $display("FAIL ascii_b2b got=%0d cycles exp=33", cyc); end
    total++;
    if (side_err != 0) begin bad++; $display("FAIL ascii_busy_ready got=%0d errors exp=0", side_err); end
    total++;
    if (resp_count !== 16'd1 || tx_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL ascii_end got count=%0d valid=%b ready=%b exp 1/0/1", resp_count, tx_valid, cmd_ready);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int k;
    send_cmd(0, 8'h56, ok);
    collect(0, 33, 50, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_len got=%0d exp=33", got.size()); end
    k = first_diff(crlf_s, 0);
    total++;
    if (k >= 0) begin bad++; $display("FAIL bp_line pos=%0d got=%h exp=%h", k, got[k], crlf_s[k]); end
    total++;
    if (hold_err != 0) begin bad++; $display("FAIL bp_hold got=%0d errors exp=0", hold_err); end
    total++;
    if (side_err != 0) begin bad++; $display("FAIL bp_ready got=%0d errors exp=0", side_err); end
    total++;
    if (resp_count !== 16'd2) begin bad++; $display("FAIL bp_count got=%0d exp=2", resp_count); end
  endtask

  task automatic test_abort;
    bit ok;
    int k;
    send_cmd(0, 8'h56, ok);
    collect(0, 10, 100, ok);
    k = first_diff(line_s.substr(0, 9), 0);
    total++;
    if (!ok || k >= 0) begin bad++; $display("FAIL abort_prefix got=%0d bytes diff=%0d exp 10/-1", got.size(), k); end
    rst = 1;
    @(negedge clk);
    total++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || resp_count !== 16'd0) begin
      bad++; $display("FAIL abort_state got valid=%b busy=%b count=%0d exp 0/0/0", tx_valid, busy, resp_count);
    end
    rst = 0;
    @(negedge clk);
    send_cmd(0, 8'h56, ok);
    collect(0, 33, 70, ok);
    k = first_diff(crlf_s, 0);
    total++;
    if (!ok || k >= 0) begin bad++; $display("FAIL abort_fresh got=%0d bytes diff=%0d exp 33/-1", got.size(), k); end
    total++;
    if (resp_count !== 16'd1) begin bad++; $display("FAIL abort_count got=%0d exp=1", resp_count); end
  endtask

  task automatic test_lf_back_to_back;
    bit ok1, ok2, okc;
    int k1, k2, cr;
    fork
      begin send_cmd(1, 8'h56, ok1); send_cmd(1, 8'h56, ok2); end
      collect(1, 64, 100, okc);
    join
    total++;
    if (!(ok1 && ok2 && okc)) begin
      bad++; $display("FAIL lf_done got cmd=%b%b bytes=%0d exp 11/64", ok1, ok2, got.size());
    end
    k1 = first_diff(lf_s, 0);
    k2 = first_diff(lf_s, 32);
    total++;
    if (k1 >= 0 || k2 >= 0) begin bad++; $display("FAIL lf_lines got diff=%0d/%0d exp -1/-1", k1, k2); end
    cr = 0;
    foreach (got[i]) if (got[i] === 8'h0D) cr++;
    total++;
    if (cr != 0) begin bad++; $display("FAIL lf_no_cr got=%0d exp=0", cr); end
    total++;
    if (side_err != 0) begin bad++; $display("FAIL lf_stall got=%0d errors exp=0", side_err); end
    total++;
    if (l_resp_count !== 16'd2) begin bad++; $display("FAIL lf_count got=%0d exp=2", l_resp_count); end
  endtask

  task automatic test_bin;
    bit ok;
    logic [15:0] c0;
    c0 = resp_count;
    send_cmd(0, 8'h76, ok);
`ifdef VERSION_RESP_BIN_EN
    begin
      logic [7:0] eb[12] = '{8'h00, 8'h00, 8'h00, 8'h3B, 8'h20, 8'h25, 8'h11, 8'h07, 8'h16, 8'h19, 8'h55, 8'h0A};
      int k;
      collect(0, 12, 60, ok);
      k = -1;
      for (int i = 11; i >= 0; i--) if (i >= got.size() || got[i] !== eb[i]) k = i;
      total++;
      if (!ok || k >= 0) begin bad++; $display("FAIL bin_bytes got=%0d bytes diff=%0d exp 12/-1", got.size(), k); end
      total++;
      if (resp_count !== c0 + 16'd1) begin bad++; $display("FAIL bin_count got=%0d exp=%0d", resp_count, c0 + 16'd1); end
    end
`else
    repeat (3) begin
      total++;
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL bin_drop got valid=%b exp=0", tx_valid); end
      @(negedge clk);
    end
    total++;
    if (resp_count !== c0) begin bad++; $display("FAIL bin_drop_count got=%0d exp=%0d", resp_count, c0); end
`endif
  endtask

  initial begin
    crlf_s = $sformatf("%s%c%c", line_s, 8'h0D, 8'h0A);
    lf_s = $sformatf("%s%c", line_s, 8'h0A);
    {cmd_data, cmd_valid, tx_ready, l_cmd_data, l_cmd_valid, l_tx_ready} = '0;
    test_reset;
    test_drop;
    test_ascii;
    test_backpressure;
    test_abort;
    test_lf_back_to_back;
    test_bin;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
